fetch_unit: RTL

- Instruction-fetch front end: the initiator side of the PC/Instr interface into the word-indexed instruction memory.
- Holds the fetch PC and drives it to the memory's PC input. Captures the returned Instr (the memory updates Instr on negedge Clk) at the following posedge.
- Buffers captured {PC, Instr} pairs in a small queue and hands them to the decode stage over a valid/ready handshake.
- Handles redirects (branch/jump) and an end-of-memory limit.

---
 rtl/fetch_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives PC into word-indexed instruction memory,
// queues returned {PC, Instr} pairs and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int          DEPTH      = 2,
    parameter int          ADDR_LIMIT = 32,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] PC,
    input  logic [31:0] Instr,
    output logic        IfValid,
    output logic [31:0] IfInstr,
    output logic [31:0] IfPC,
    input  logic        IdReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Done
);
    localparam int            PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam logic [31:0]   LIMIT = 32'(ADDR_LIMIT);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          pending, push, pop;
    logic [31:0]   pc_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A redirect discards the word being read this cycle, so it never captures.
    always_comb begin
        push       = pending && !Redirect;
        pop        = IfValid && IdReady;
        count_next = count + CW'(push) - CW'(pop);
        pc_next    = push ? PC + 32'd1 : PC;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC      <= RESET_PC;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (Redirect) begin
            PC      <= RedirectPC;
            pending <= (RedirectPC < LIMIT);
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_next;
            PC      <= pc_next;
            pending <= (count_next < FULL) && (pc_next < LIMIT);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= PC;
            q_instr[wr_ptr] <= Instr;
        end
    end

    assign IfValid = (count != '0);
    assign IfPC    = IfValid ? q_pc[rd_ptr]    : '0;
    assign IfInstr = IfValid ? q_instr[rd_ptr] : '0;
    assign Done    = (PC >= LIMIT) && !pending && (count == '0);

    overflow_check: assert property (@(posedge Clk) disable iff (Reset)
        !(push && !pop && count == FULL));

endmodule
